// File: rtl/control_pkg.sv
// Shared constants for the multi-cycle MIPS-style control unit:
// opcodes, ALU operation codes, instruction classes and FSM state encoding.
package control_pkg;

    // Opcodes, Instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    // ALU operation codes (R-type func field uses the same values)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOT = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_ROL = 4'b1100;
    localparam logic [3:0] ALU_ROR = 4'b1101;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_IMM,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } instr_class_t;

    // FSM state encoding
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_DEC = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_ERR = 3'd5;

    // Opcode field of an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder: classifies the instruction word and
// produces the datapath selects and ALU operation for it.
module control_decoder
    import control_pkg::*;
#(
    parameter int ALU_FUNC_W = 4
) (
    input  logic [31:0]           instr,
    output instr_class_t          cls,
    output logic                  is_beq,
    output logic                  is_bne,
    output logic                  alu_bin_sel,
    output logic                  rf_b_sel,
    output logic                  lui,
    output logic                  lb,
    output logic                  sb,
    output logic [ALU_FUNC_W-1:0] alu_func
);

    localparam int FW = (ALU_FUNC_W < 6) ? ALU_FUNC_W : 6;

    // Opcode lookup; the all-zero word is a nop even though its opcode matches beq
    always_comb begin
        cls         = CLS_ILLEGAL;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        alu_bin_sel = 1'b0;
        rf_b_sel    = 1'b0;
        lui         = 1'b0;
        lb          = 1'b0;
        sb          = 1'b0;
        alu_func    = ALU_FUNC_W'(ALU_ADD);
        if (instr == 32'd0) begin
            cls = CLS_NOP;
        end else begin
            case (opcode_of(instr))
                OP_RTYPE: begin
                    cls      = CLS_ALU;
                    alu_func = ALU_FUNC_W'(instr[FW-1:0]);
                end
                OP_LI, OP_ADDI: begin
                    cls         = CLS_IMM;
                    alu_bin_sel = 1'b1;
                end
                OP_LUI: begin
                    cls         = CLS_IMM;
                    alu_bin_sel = 1'b1;
                    lui         = 1'b1;
                end
                OP_ANDI: begin
                    cls         = CLS_IMM;
                    alu_bin_sel = 1'b1;
                    alu_func    = ALU_FUNC_W'(ALU_AND);
                end
                OP_ORI: begin
                    cls         = CLS_IMM;
                    alu_bin_sel = 1'b1;
                    alu_func    = ALU_FUNC_W'(ALU_OR);
                end
                OP_B: begin
                    cls = CLS_BRANCH;
                end
                OP_BEQ: begin
                    cls      = CLS_BRANCH;
                    is_beq   = 1'b1;
                    rf_b_sel = 1'b1;
                    alu_func = ALU_FUNC_W'(ALU_SUB);
                end
                OP_BNE: begin
                    cls      = CLS_BRANCH;
                    is_bne   = 1'b1;
                    rf_b_sel = 1'b1;
                    alu_func = ALU_FUNC_W'(ALU_SUB);
                end
                OP_LB: begin
                    cls         = CLS_LOAD;
                    alu_bin_sel = 1'b1;
                    lb          = 1'b1;
                end
                OP_LW: begin
                    cls         = CLS_LOAD;
                    alu_bin_sel = 1'b1;
                end
                OP_SB: begin
                    cls         = CLS_STORE;
                    alu_bin_sel = 1'b1;
                    rf_b_sel    = 1'b1;
                    sb          = 1'b1;
                end
                OP_SW: begin
                    cls         = CLS_STORE;
                    alu_bin_sel = 1'b1;
                    rf_b_sel    = 1'b1;
                end
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, with
// req/ack memory handshakes, a handshake timeout trap and a retire counter.
module multicycle_control
    import control_pkg::*;
#(
    parameter int ALU_FUNC_W  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [31:0]           Instr,
    input  logic                  Zero,
    input  logic                  IMem_Ack,
    input  logic                  DMem_Ack,
    output logic                  IMem_Req,
    output logic                  Instr_LdEn,
    output logic                  PC_sel,
    output logic                  PC_LdEn,
    output logic                  RF_WrEn,
    output logic                  RF_WrData_sel,
    output logic                  RF_B_sel,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  Mem_RdEn,
    output logic                  Mem_WrEn,
    output logic                  lui,
    output logic                  lb,
    output logic                  sb,
    output logic                  Error,
    output logic [CNT_W-1:0]      Retired
);

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [7:0]            tmo_cnt;
    logic [CNT_W-1:0]      retired_q;
    logic                  req;
    logic                  ack;
    logic                  tmo_hit;
    logic                  sel_valid;

    instr_class_t          cls;
    logic                  is_beq;
    logic                  is_bne;
    logic                  dec_bin_sel;
    logic                  dec_rf_b_sel;
    logic                  dec_lui;
    logic                  dec_lb;
    logic                  dec_sb;
    logic [ALU_FUNC_W-1:0] dec_alu_func;

    control_decoder #(.ALU_FUNC_W(ALU_FUNC_W)) u_decoder (
        .instr       (Instr),
        .cls         (cls),
        .is_beq      (is_beq),
        .is_bne      (is_bne),
        .alu_bin_sel (dec_bin_sel),
        .rf_b_sel    (dec_rf_b_sel),
        .lui         (dec_lui),
        .lb          (dec_lb),
        .sb          (dec_sb),
        .alu_func    (dec_alu_func)
    );

    // Outstanding memory request and its matching ack; an ack on the last allowed cycle beats the timeout
    always_comb begin
        req       = (state == S_IF) || (state == S_MEM);
        ack       = (state == S_IF) ? IMem_Ack : DMem_Ack;
        tmo_hit   = req && !ack && (tmo_cnt == 8'(MEM_TIMEOUT - 1));
        sel_valid = (state == S_EX) || (state == S_MEM) || (state == S_WB);
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            S_IF: begin
                if (IMem_Ack)     next_state = S_DEC;
                else if (tmo_hit) next_state = S_ERR;
            end
            S_DEC: begin
                if (cls == CLS_ILLEGAL)  next_state = S_ERR;
                else if (cls == CLS_NOP) next_state = S_IF;
                else                     next_state = S_EX;
            end
            S_EX: begin
                if (cls == CLS_BRANCH)                         next_state = S_IF;
                else if (cls == CLS_LOAD || cls == CLS_STORE)  next_state = S_MEM;
                else                                           next_state = S_WB;
            end
            S_MEM: begin
                if (DMem_Ack)     next_state = (cls == CLS_STORE) ? S_IF : S_WB;
                else if (tmo_hit) next_state = S_ERR;
            end
            S_WB:    next_state = S_IF;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ERR;
        endcase
    end

    // State, timeout counter and retire counter registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_IF;
            tmo_cnt   <= 8'd0;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || !req || ack) tmo_cnt <= 8'd0;
            else                                    tmo_cnt <= tmo_cnt + 8'd1;
            if (PC_LdEn) retired_q <= retired_q + 1'b1;
        end
    end

    // Control outputs decoded from state and instruction, all held low during Reset
    always_comb begin
        IMem_Req      = 1'b0;
        Instr_LdEn    = 1'b0;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = '0;
        Mem_RdEn      = 1'b0;
        Mem_WrEn      = 1'b0;
        lui           = 1'b0;
        lb            = 1'b0;
        sb            = 1'b0;
        Error         = 1'b0;
        Retired       = Reset ? '0 : retired_q;
        if (!Reset) begin
            if (sel_valid) begin
                RF_B_sel    = dec_rf_b_sel;
                ALU_Bin_sel = dec_bin_sel;
                ALU_func    = dec_alu_func;
                lui         = dec_lui;
                lb          = dec_lb;
                sb          = dec_sb;
            end
            case (state)
                S_IF: begin
                    IMem_Req   = 1'b1;
                    Instr_LdEn = IMem_Ack;
                end
                S_DEC: begin
                    PC_LdEn = (cls == CLS_NOP);
                end
                S_EX: begin
                    if (cls == CLS_BRANCH) begin
                        PC_LdEn = 1'b1;
                        PC_sel  = is_beq ? Zero : (is_bne ? ~Zero : 1'b1);
                    end
                end
                S_MEM: begin
                    Mem_RdEn = (cls == CLS_LOAD);
                    Mem_WrEn = (cls == CLS_STORE);
                    PC_LdEn  = DMem_Ack && (cls == CLS_STORE);
                end
                S_WB: begin
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = (cls == CLS_LOAD);
                    PC_LdEn       = 1'b1;
                end
                S_ERR: begin
                    Error = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle CONTROL unit for the project1 MIPS-style datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with instruction and data memories (req/ack with timeout), counts retired instructions, and traps on illegal opcodes or memory timeouts.

Parameters:
ALU_FUNC_W, 4, width of ALU_func; func[ALU_FUNC_W-1:0] passed for R-type.
MEM_TIMEOUT, 16, cycles a req may wait for ack before trapping; legal range 1..255.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Instr  in  32  instruction register contents; opcode [31:26], rs [25:21], rd [20:16], rt [15:11], func [5:0]
Zero  in  1  ALU zero flag, sampled in S_EX
IMem_Ack  in  1  instruction memory ack
DMem_Ack  in  1  data memory ack
IMem_Req  out  1  instruction fetch request
Instr_LdEn  out  1  load instruction register
PC_sel  out  1  0 = PC+4, 1 = branch target
PC_LdEn  out  1  PC update, exactly one pulse per retired instruction
RF_WrEn  out  1  register file write
RF_WrData_sel  out  1  0 = ALU, 1 = memory
RF_B_sel  out  1  0 = rt, 1 = rd
ALU_Bin_sel  out  1  0 = RF B, 1 = immediate
ALU_func  out  ALU_FUNC_W  ALU operation
Mem_RdEn  out  1  data read request
Mem_WrEn  out  1  data write request
lui, lb, sb  out  1 each  lui immediate shift / byte load / byte store
Error  out  1  sticky trap flag
Retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset: state goes to S_IF, timeout counter to 0, Retired to 0, Error to 0. While Reset is high, every output is forced to 0. Acks are ignored during Reset.
- States: S_IF, S_DEC, S_EX, S_MEM, S_WB, S_ERR. Control outputs are combinational from state and Instr; state is registered.
- S_IF:
  - IMem_Req=1.
  - On IMem_Ack: Instr_LdEn=1 in the same cycle; next state S_DEC.
- S_DEC:
  - Illegal opcode goes to S_ERR.
  - Instr==0 (nop): PC_LdEn=1, PC_sel=0, Retired++, next state S_IF.
  - All other legal opcodes go to S_EX.
- Opcodes: 100000 R-type; 111000 li; 111001 lui; 110000 addi; 110010 andi; 110011 ori; 111111 b; 000000 beq; 000001 bne; 000011 lb; 001111 lw; 000111 sb; 011111 sw.
- ALU_func:
  - R-type: func[ALU_FUNC_W-1:0].
  - andi: 0010. ori: 0011. beq/bne: 0001.
  - All other opcodes: 0000.
- Datapath selects:
  - ALU_Bin_sel=1 for immediate, load and store opcodes.
  - RF_B_sel=1 for beq, bne, sb and sw.
  - lui, lb and sb assert for their own opcodes.
  - These selects and ALU_func are held valid in S_EX, S_MEM and S_WB. They are 0 in S_IF and S_ERR.
- S_EX:
  - beq: PC_sel=Zero. bne: PC_sel=~Zero. b: PC_sel=1. For all three, PC_LdEn=1, Retired++, next state S_IF.
  - ALU and immediate ops go to S_WB.
  - Loads and stores go to S_MEM.
- S_MEM:
  - Mem_RdEn (loads) or Mem_WrEn (stores) is held until DMem_Ack.
  - Store ack: PC_LdEn=1, PC_sel=0, Retired++, next state S_IF.
  - Load ack: next state S_WB.
- S_WB:
  - RF_WrEn=1; RF_WrData_sel=1 for loads.
  - PC_LdEn=1, PC_sel=0, Retired++, next state S_IF.
- Latency with zero-wait acks, in cycles: nop 2, branch 3, ALU op 4, store 4, load 5. Each wait cycle adds 1.
- Timeout:
  - The counter increments each cycle a req is high without ack, and clears on ack or state change.
  - When it reaches MEM_TIMEOUT without ack, next state is S_ERR.
  - An ack in the same cycle the limit is reached takes precedence over the timeout.
- S_ERR: all enables and requests are 0, Error=1. S_ERR is absorbing until Reset.
- Reset mid-instruction aborts it: no PC_LdEn, no RF_WrEn, Retired unchanged.

Decomposition:
- control_pkg holds:
  - opcode constants and func codes;
  - ALU_func codes: add 0000, sub 0001, and 0010, or 0011, not 0100, sra 1000, srl 1001, sll 1010, rol 1100, ror 1101;
  - state encoding.
- One combinational sub-module, control_decoder: maps Instr to instruction class (nop, alu, imm, branch, load, store, illegal) plus datapath selects and ALU_func.
- multicycle_control keeps the FSM, timeout counter and retire counter.

Test Plan:
- Reset held 2 cycles, then Instr=0x00000000 with IMem_Ack=1 -> outputs 0 during Reset; IMem_Req=1 in cycle 1; PC_LdEn=1 and PC_sel=0 in cycle 2; Retired=1.
- Instr=0xE0010002 (li $1,2), acks immediate -> S_WB on cycle 4 with RF_WrEn=1, ALU_Bin_sel=1, ALU_func=0000, RF_WrData_sel=0, PC_LdEn=1.
- Instr=0x80461030 (add $6,$2,$2) -> ALU_func=0000, ALU_Bin_sel=0, RF_B_sel=0; RF_WrEn on cycle 4.
- Instr=0x01C20003 (beq $14,$2,3), Zero=1 then rerun with Zero=0 -> in S_EX, ALU_func=0001, RF_B_sel=1, PC_sel=1 then 0; PC_LdEn=1; no RF_WrEn in either run.
- sw with DMem_Ack after 3 waits, then lw with ack on the MEM_TIMEOUT-th cycle -> Mem_WrEn held 4 cycles; the load completes with RF_WrData_sel=1 because ack wins over timeout.
- IMem_Ack never asserted; then, separately, opcode 101010 -> Error=1 after MEM_TIMEOUT cycles; illegal opcode traps from S_DEC; both stay in S_ERR until Reset, then resume fetch.
